// File: rtl/gnrc_afifo_pkg.sv
// ----------------------------------------------------------------------------
// gnrc_afifo_pkg
// Shared types and helpers for the async FIFO pointer blocks.
//   ptr_mode_e     : selects whether a pointer block is the write side (flag =
//                    full) or the read side (flag = empty).
//   gray_full_cmp  : compares a local Gray pointer with a remote Gray pointer
//                    and reports "full". The two pointers are exactly one lap
//                    apart when the top two Gray bits differ and the rest match.
//                    Operands are zero-extended to 64 bits; w is the real
//                    pointer width (>= 3).
// ----------------------------------------------------------------------------
package gnrc_afifo_pkg;

    typedef enum logic {
        PTR_WR = 1'b0,
        PTR_RD = 1'b1
    } ptr_mode_e;

    localparam int GRAY_CMP_W = 64;

    // Full means "one whole lap ahead". In Gray code that is the remote value
    // with its two most significant bits inverted.
    function automatic logic gray_full_cmp(
        input logic [GRAY_CMP_W-1:0] gray,
        input logic [GRAY_CMP_W-1:0] rgray,
        input int unsigned           w
    );
        logic [GRAY_CMP_W-1:0] wmask;
        logic [GRAY_CMP_W-1:0] tmask;
        wmask = (w >= GRAY_CMP_W) ? '1 : ((64'd1 << w) - 64'd1);
        tmask = 64'd3 << (w - 2);
        return ((gray ^ tmask) & wmask) == (rgray & wmask);
    endfunction

endpackage

// File: rtl/gnrc_bin2gray.sv
// ----------------------------------------------------------------------------
// gnrc_bin2gray
// Purely combinational binary to Gray conversion.
//   N      : word width
//   bin_i  : binary input  [N-1:0]
//   gray_o : Gray output   [N-1:0]
// ----------------------------------------------------------------------------
module gnrc_bin2gray #(
    parameter int N = 4
) (
    input  logic [N-1:0] bin_i,
    output logic [N-1:0] gray_o
);

    // Each Gray bit is the XOR of a binary bit with its upper neighbour.
    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gnrc_gray2bin.sv
// ----------------------------------------------------------------------------
// gnrc_gray2bin
// Purely combinational Gray to binary conversion.
//   N      : word width
//   gray_i : Gray input    [N-1:0]
//   bin_o  : binary output [N-1:0]
// ----------------------------------------------------------------------------
module gnrc_gray2bin #(
    parameter int N = 4
) (
    input  logic [N-1:0] gray_i,
    output logic [N-1:0] bin_o
);

    // Binary bit i is the XOR of all Gray bits from the MSB down to i.
    // Written as a reduction per bit so there is no chain through bin_o.
    for (genvar i = 0; i < N; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[N-1:i];
    end

endmodule

// File: rtl/gnrc_afifo_ptr.sv
// ----------------------------------------------------------------------------
// gnrc_afifo_ptr
// One pointer domain of an asynchronous FIFO. It holds the binary address
// counter, the registered Gray pointer handed to the other clock domain, the
// synchroniser for the other domain's Gray pointer, and the full flag (write
// side) or empty flag (read side).
//
// Parameters
//   AW          : address width, FIFO depth = 2**AW (>= 2)
//   SYNC_STAGES : flops in the remote pointer synchroniser (>= 2)
//   MODE        : PTR_WR -> flag_o is full, PTR_RD -> flag_o is empty
//
// Ports
//   clk_i         : local domain clock
//   rst_i         : synchronous active-high reset
//   inc_i         : advance request (push on write side, pop on read side)
//   remote_gray_i : Gray pointer from the other domain (asynchronous)
//   ptr_gray_o    : registered Gray pointer sent to the other domain
//   addr_o        : RAM address, low AW bits of the binary counter
//   flag_o        : registered full (PTR_WR) or empty (PTR_RD)
//   level_o       : registered occupancy, present only when the macro
//                   GNRC_AFIFO_PTR_LEVEL_EN is defined
// ----------------------------------------------------------------------------
module gnrc_afifo_ptr
    import gnrc_afifo_pkg::*;
#(
    parameter int        AW          = 4,
    parameter int        SYNC_STAGES = 2,
    parameter ptr_mode_e MODE        = PTR_WR
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          inc_i,
    input  logic [AW:0]   remote_gray_i,
    output logic [AW:0]   ptr_gray_o,
    output logic [AW-1:0] addr_o,
    output logic          flag_o
`ifdef GNRC_AFIFO_PTR_LEVEL_EN
   ,output logic [AW:0]   level_o
`endif
);

    // The read side starts empty, the write side starts not-full.
    localparam logic FLAG_RST = (MODE == PTR_RD);

    logic [AW:0] bin_q;
    logic [AW:0] bin_d;
    logic [AW:0] gray_d;
    logic [AW:0] ptr_gray_q;
    logic        flag_q;
    logic        flag_d;
    logic        incEff;
    logic [AW:0] sync_q [SYNC_STAGES];
    logic [AW:0] rsync;

    // An increment is only honoured when the flag registered at this edge is
    // clear, so a push into a full FIFO or a pop from an empty one is dropped.
    assign incEff = inc_i & ~flag_q;
    assign bin_d  = bin_q + {{AW{1'b0}}, incEff};
    assign rsync  = sync_q[SYNC_STAGES-1];

    gnrc_bin2gray #(
        .N (AW+1)
    ) u_bin2gray (
        .bin_i  (bin_d),
        .gray_o (gray_d)
    );

    // The flag looks at the next pointer value so the access that fills or
    // empties the FIFO raises the flag on the very next cycle.
    always_comb begin
        flag_d = 1'b0;
        if (MODE == PTR_WR) begin
            flag_d = gray_full_cmp(64'(gray_d), 64'(rsync), AW + 1);
        end else begin
            flag_d = (gray_d == rsync);
        end
    end

    // Local pointer state and flag. The Gray output comes straight from a
    // flop so the other domain never sees combinational glitches.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bin_q      <= '0;
            ptr_gray_q <= '0;
            flag_q     <= FLAG_RST;
        end else begin
            bin_q      <= bin_d;
            ptr_gray_q <= gray_d;
            flag_q     <= flag_d;
        end
    end

    // Remote pointer synchroniser. Reset clears every stage so stale values
    // from before the reset cannot leak into the flag afterwards.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= remote_gray_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign ptr_gray_o = ptr_gray_q;
    assign addr_o     = bin_q[AW-1:0];
    assign flag_o     = flag_q;

`ifdef GNRC_AFIFO_PTR_LEVEL_EN
    logic [AW:0] rbin;
    logic [AW:0] level_q;
    logic [AW:0] level_d;

    gnrc_gray2bin #(
        .N (AW+1)
    ) u_gray2bin (
        .gray_i (rsync),
        .bin_o  (rbin)
    );

    // Occupancy is the modular distance between the two binary pointers,
    // taken from the writer's point of view on either side.
    always_comb begin
        level_d = '0;
        if (MODE == PTR_WR) begin
            level_d = bin_d - rbin;
        end else begin
            level_d = rbin - bin_d;
        end
    end

    // Occupancy register, cleared with the rest of the pointer state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level_o = level_q;
`endif

endmodule

// File: tb/tb_gnrc_afifo_ptr.sv
// ----------------------------------------------------------------------------
// tb_gnrc_afifo_ptr
// Drives one write-side and one read-side pointer block (AW=2, two sync
// stages). Stimulus is applied on the falling edge; the expected outputs after
// the following rising edge come from an arithmetic occupancy model and are
// queued. A monitor pops and compares one record per rising edge.
// ----------------------------------------------------------------------------
module tb_gnrc_afifo_ptr;
    import gnrc_afifo_pkg::*;

    localparam int AW    = 2;
    localparam int SS    = 2;
    localparam int W     = AW + 1;
    localparam int MOD   = 1 << W;
    localparam int DEPTH = 1 << AW;

    logic         clk = 1'b0;
    logic         rst;
    logic         incWr;
    logic         incRd;
    logic [AW:0]  remWrGray;
    logic [AW:0]  remRdGray;
    logic [AW:0]  wrGray;
    logic [AW:0]  rdGray;
    logic [AW-1:0] wrAddr;
    logic [AW-1:0] rdAddr;
    logic         wrFlag;
    logic         rdFlag;
`ifdef GNRC_AFIFO_PTR_LEVEL_EN
    logic [AW:0]  wrLevel;
    logic [AW:0]  rdLevel;
`endif

    typedef struct {
        int gray;
        int addr;
        int flag;
        int level;
    } side_t;

    typedef struct {
        side_t wr;
        side_t rd;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;

    int   mCnt[2];
    int   mS0[2];
    int   mS1[2];
    int   mFlag[2];
    int   mLevel[2];
    int   remWr;
    int   remRd;
    bit   stimDone = 1'b0;

    always #5 clk = ~clk;

    gnrc_afifo_ptr #(.AW(AW), .SYNC_STAGES(SS), .MODE(PTR_WR)) dutWr (
        .clk_i         (clk),
        .rst_i         (rst),
        .inc_i         (incWr),
        .remote_gray_i (remWrGray),
        .ptr_gray_o    (wrGray),
        .addr_o        (wrAddr),
        .flag_o        (wrFlag)
`ifdef GNRC_AFIFO_PTR_LEVEL_EN
       ,.level_o       (wrLevel)
`endif
    );

    gnrc_afifo_ptr #(.AW(AW), .SYNC_STAGES(SS), .MODE(PTR_RD)) dutRd (
        .clk_i         (clk),
        .rst_i         (rst),
        .inc_i         (incRd),
        .remote_gray_i (remRdGray),
        .ptr_gray_o    (rdGray),
        .addr_o        (rdAddr),
        .flag_o        (rdFlag)
`ifdef GNRC_AFIFO_PTR_LEVEL_EN
       ,.level_o       (rdLevel)
`endif
    );

    function automatic int md(input int v);
        return ((v % MOD) + MOD) % MOD;
    endfunction

    function automatic int grayOf(input int v);
        return v ^ (v >> 1);
    endfunction

    // Occupancy model: side 0 is the writer (remote = read count), side 1 is
    // the reader (remote = write count). The flag compares the next local count
    // against the remote count seen SS edges earlier.
    task automatic modelStep(input int side, input bit r, input bit inc,
                             input int rem, output side_t e);
        int eff;
        int nxt;
        int rs;
        if (r) begin
            mCnt[side]   = 0;
            mS0[side]    = 0;
            mS1[side]    = 0;
            mFlag[side]  = (side == 1) ? 1 : 0;
            mLevel[side] = 0;
        end else begin
            eff = (inc && mFlag[side] == 0) ? 1 : 0;
            nxt = md(mCnt[side] + eff);
            rs  = mS1[side];
            if (side == 0) begin
                mFlag[side]  = (md(nxt - rs) == DEPTH) ? 1 : 0;
                mLevel[side] = md(nxt - rs);
            end else begin
                mFlag[side]  = (nxt == rs) ? 1 : 0;
                mLevel[side] = md(rs - nxt);
            end
            mCnt[side] = nxt;
            mS1[side]  = mS0[side];
            mS0[side]  = rem;
        end
        e.gray  = grayOf(mCnt[side]);
        e.addr  = mCnt[side] % DEPTH;
        e.flag  = mFlag[side];
        e.level = mLevel[side];
    endtask

    task automatic applyStimulus(input bit r, input bit iw, input bit ir,
                                 input int rw, input int rr);
        exp_t e;
        @(negedge clk);
        rst       = r;
        incWr     = iw;
        incRd     = ir;
        remWrGray = W'(grayOf(md(rw)));
        remRdGray = W'(grayOf(md(rr)));
        modelStep(0, r, iw, md(rw), e.wr);
        modelStep(1, r, ir, md(rr), e.rd);
        expQ.push_back(e);
    endtask

    task automatic checkField(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkField("wr_gray", int'(wrGray), e.wr.gray);
        checkField("wr_addr", int'(wrAddr), e.wr.addr);
        checkField("wr_full", int'(wrFlag), e.wr.flag);
        checkField("rd_gray", int'(rdGray), e.rd.gray);
        checkField("rd_addr", int'(rdAddr), e.rd.addr);
        checkField("rd_empty", int'(rdFlag), e.rd.flag);
`ifdef GNRC_AFIFO_PTR_LEVEL_EN
        checkField("wr_level", int'(wrLevel), e.wr.level);
        checkField("rd_level", int'(rdLevel), e.rd.level);
`endif
    endtask

    // Monitor: one expected record per rising edge, sampled 1 time unit later.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                checkOutput(expQ.pop_front());
            end
        end
    end

    // Stimulus: directed scenarios followed by a randomized run.
    initial begin
        rst       = 1'b1;
        incWr     = 1'b0;
        incRd     = 1'b0;
        remWrGray = '0;
        remRdGray = '0;

        // Reset held with increments requested.
        repeat (3) applyStimulus(1, 1, 1, 0, 0);

        // Fill the write side against a stalled reader; fifth push dropped.
        // Pops on the empty read side are dropped as well.
        repeat (5) applyStimulus(0, 1, 1, 0, 0);

        // Remote writer advances to 1; empty falls after the sync latency,
        // then a single pop empties it again.
        repeat (4) applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 1);
        repeat (2) applyStimulus(0, 0, 0, 0, 1);

        // Wrap: writer pushes a full lap with the reader tracking two behind.
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, 0, mCnt[0] + 6, 0);
        end
        repeat (2) applyStimulus(0, 0, 0, mCnt[0] + 6, 0);

        // Mid-operation reset with non-zero remote pointers in the synchronisers.
        applyStimulus(1, 0, 0, 0, 0);
        repeat (3) applyStimulus(0, 1, 0, 1, 2);
        repeat (2) applyStimulus(0, 0, 0, 1, 2);
        applyStimulus(1, 0, 0, 1, 2);
        repeat (4) applyStimulus(0, 0, 0, 0, 0);

        // Randomized traffic. Remote pointers only move in legal directions:
        // the reader never passes the writer and the writer stays within a lap.
        remWr = 0;
        remRd = 0;
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 1500; i++) begin
            bit r;
            bit iw;
            bit ir;
            r  = ($urandom_range(199) == 0);
            iw = ($urandom_range(3) != 0);
            ir = ($urandom_range(1) == 0);
            if (r) begin
                remWr = 0;
                remRd = 0;
            end else begin
                if (md(mCnt[0] - remWr) > 0 && $urandom_range(2) == 0) begin
                    remWr = md(remWr + 1);
                end
                if (md(remRd - mCnt[1]) < DEPTH && $urandom_range(2) != 0) begin
                    remRd = md(remRd + 1);
                end
            end
            applyStimulus(r, iw, ir, remWr, remRd);
        end
        stimDone = 1'b1;
    end

    // Completion: wait for the scoreboard to drain, bounded in cycles.
    initial begin
        int budget;
        wait (stimDone);
        budget = 0;
        while (expQ.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        @(posedge clk);
        #2;
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain actual=%0d required=0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
